oled_fb_arbiter: RTL and testbench



---
 rtl/oled_pkg.sv | 26 ++
 rtl/oled_fb_arbiter_if.sv | 49 ++++
 rtl/oled_fb_ram.sv | 43 ++++
 rtl/oled_fb_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_oled_fb_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
//------------------------------------------------------------------------------
// Module : oled_pkg
// Brief  : Shared frame-buffer geometry and arbiter state encoding.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package oled_pkg;

  localparam int FB_DEPTH  = 1024;
  localparam int FB_ADDR_W = 10;
  localparam int PIX_W     = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int rr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/oled_fb_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : oled_fb_arbiter_if
// Brief  : Reader/writer bus of the frame-buffer arbiter; OLED_ARB_CLEAR_EN adds
//          the clear handshake.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface oled_fb_arbiter_if
  import oled_pkg::*;
#(
  parameter int NUM_WRITERS = 2
) ();

  logic [FB_ADDR_W-1:0]             pixel_address;
  logic [PIX_W-1:0]                 pixel_data;
  logic                             pixel_valid;
  logic [NUM_WRITERS-1:0]           wr_req;
  logic [NUM_WRITERS*FB_ADDR_W-1:0] wr_addr;
  logic [NUM_WRITERS*PIX_W-1:0]     wr_data;
  logic [NUM_WRITERS-1:0]           wr_grant;
`ifdef OLED_ARB_CLEAR_EN
  logic                             clear_req;
  logic                             clear_busy;

  modport slave (
    input  pixel_address, wr_req, wr_addr, wr_data, clear_req,
    output pixel_data, pixel_valid, wr_grant, clear_busy
  );

  modport master (
    output pixel_address, wr_req, wr_addr, wr_data, clear_req,
    input  pixel_data, pixel_valid, wr_grant, clear_busy
  );
`else
  modport slave (
    input  pixel_address, wr_req, wr_addr, wr_data,
    output pixel_data, pixel_valid, wr_grant
  );

  modport master (
    output pixel_address, wr_req, wr_addr, wr_data,
    input  pixel_data, pixel_valid, wr_grant
  );
`endif

endinterface

`default_nettype wire

// File: rtl/oled_fb_ram.sv
//------------------------------------------------------------------------------
// Module : oled_fb_ram
// Brief  : Single-port 1024x8 screen buffer, synchronous read, BSRAM style.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module oled_fb_ram
  import oled_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 i_we,
  input  wire logic                 i_re,
  input  wire logic [FB_ADDR_W-1:0] i_addr,
  input  wire logic [PIX_W-1:0]     i_wdata,
  output logic      [PIX_W-1:0]     o_rdata
);

  // Array is left without reset so it maps to block RAM, which powers up zeroed.
  logic [PIX_W-1:0] r_mem [FB_DEPTH];
  logic [PIX_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Output only moves on a served read, so writes never disturb pixel_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/oled_fb_arbiter.sv
//------------------------------------------------------------------------------
// Module : oled_fb_arbiter
// Brief  : Shares the OLED frame-buffer RAM port between the panel reader and
//          round-robin writers with starvation relief; OLED_ARB_CLEAR_EN adds
//          a whole-screen clear.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module oled_fb_arbiter
  import oled_pkg::*;
#(
  parameter int NUM_WRITERS = 2,
  parameter int MAX_STARVE  = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  oled_fb_arbiter_if.slave bus
);

  localparam int             RR_W         = rr_width(NUM_WRITERS);
  localparam logic [7:0]     C_MAX_STARVE = 8'(MAX_STARVE);
  localparam logic [RR_W-1:0] C_LAST_IDX  = RR_W'(NUM_WRITERS - 1);

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic                   w_clear_active;

  logic [RR_W-1:0]        r_rr_ptr;
  logic [RR_W-1:0]        w_rr_idx;
  logic [RR_W-1:0]        w_rr_nxt;
  logic                   w_rr_found;

  logic [7:0]             r_starve;
  logic                   r_served_valid;
  logic [FB_ADDR_W-1:0]   r_served_addr;

  logic                   w_any_req;
  logic                   w_forced;
  logic                   w_read_pending;
  logic                   w_do_read;
  logic                   w_do_write;
  logic [FB_ADDR_W-1:0]   w_wr_addr;
  logic [PIX_W-1:0]       w_wr_data;
  logic [NUM_WRITERS-1:0] w_grant;

  logic                   w_ram_we;
  logic [FB_ADDR_W-1:0]   w_ram_addr;
  logic [PIX_W-1:0]       w_ram_wdata;
  logic [PIX_W-1:0]       w_ram_rdata;

`ifdef OLED_ARB_CLEAR_EN
  logic [FB_ADDR_W-1:0]   r_clr_addr;
`endif

  //--------------------------------------------------------------------------
  // Clear FSM: state register / next state / outputs
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef OLED_ARB_CLEAR_EN
    case (r_state)
      ST_IDLE:  if (bus.clear_req) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_clr_addr == FB_ADDR_W'(FB_DEPTH - 1)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
`else
    w_state_nxt = ST_IDLE;
`endif
  end

  always_comb begin
    w_clear_active = (r_state == ST_CLEAR);
  end

`ifdef OLED_ARB_CLEAR_EN
  assign bus.clear_busy = w_clear_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_addr <= '0;
    end else if (w_clear_active) begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end
  end
`endif

  //--------------------------------------------------------------------------
  // Round-robin search starting at r_rr_ptr; lowest offset wins
  //--------------------------------------------------------------------------
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = NUM_WRITERS - 1; k >= 0; k--) begin
      if (bus.wr_req[(int'(r_rr_ptr) + k) % NUM_WRITERS]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = RR_W'((int'(r_rr_ptr) + k) % NUM_WRITERS);
      end
    end
  end

  always_comb begin
    w_rr_nxt = (w_rr_idx == C_LAST_IDX) ? '0 : w_rr_idx + 1'b1;
  end

  //--------------------------------------------------------------------------
  // One RAM operation per cycle: forced write, read, round-robin write
  //--------------------------------------------------------------------------
  always_comb begin
    w_any_req      = |bus.wr_req;
    w_forced       = (r_starve == C_MAX_STARVE) && w_any_req;
    w_read_pending = !r_served_valid || (bus.pixel_address != r_served_addr);
    w_do_write     = !w_clear_active && w_rr_found && (w_forced || !w_read_pending);
    w_do_read      = !w_clear_active && w_read_pending && !w_forced;
    w_wr_addr      = bus.wr_addr[int'(w_rr_idx)*FB_ADDR_W +: FB_ADDR_W];
    w_wr_data      = bus.wr_data[int'(w_rr_idx)*PIX_W +: PIX_W];
  end

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NUM_WRITERS; i++) begin
      if (w_do_write && (int'(w_rr_idx) == i)) begin
        w_grant[i] = 1'b1;
      end
    end
  end

  // Grant is masked by rst_n so an in-flight write never reports commit.
  assign bus.wr_grant = w_grant & {NUM_WRITERS{rst_n}};

  always_comb begin
    w_ram_we    = rst_n && w_do_write;
    w_ram_addr  = w_do_write ? w_wr_addr : bus.pixel_address;
    w_ram_wdata = w_wr_data;
`ifdef OLED_ARB_CLEAR_EN
    if (w_clear_active) begin
      w_ram_we    = rst_n;
      w_ram_addr  = r_clr_addr;
      w_ram_wdata = '0;
    end
`endif
  end

  //--------------------------------------------------------------------------
  // Pointer, starvation counter and served-read tracking
  //--------------------------------------------------------------------------
  if (NUM_WRITERS > 1) begin : g_rr_ptr
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rr_ptr <= '0;
      end else if (w_do_write) begin
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end else begin : g_rr_fixed
    assign r_rr_ptr = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!w_clear_active) begin
      if (w_do_write || !w_any_req) begin
        r_starve <= '0;
      end else if (r_starve != C_MAX_STARVE) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  // A write hitting the displayed byte invalidates it so the reader refetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_served_valid <= 1'b0;
      r_served_addr  <= '0;
    end else if (w_clear_active) begin
      r_served_valid <= 1'b0;
    end else if (w_do_read) begin
      r_served_valid <= 1'b1;
      r_served_addr  <= bus.pixel_address;
    end else if (w_do_write && (w_wr_addr == r_served_addr)) begin
      r_served_valid <= 1'b0;
    end
  end

  assign bus.pixel_valid = r_served_valid && (bus.pixel_address == r_served_addr);
  assign bus.pixel_data  = w_ram_rdata;

  oled_fb_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_ram_we),
    .i_re    (w_do_read),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_oled_fb_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_oled_fb_arbiter
// Brief  : Directed self-checking bench for oled_fb_arbiter (OLED_ARB_CLEAR_EN
//          adds the clear scenario).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_oled_fb_arbiter;
  import oled_pkg::*;

  localparam int NW = 2;
  localparam int MS = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  oled_fb_arbiter_if #(.NUM_WRITERS(NW)) bus ();

  oled_fb_arbiter #(
    .NUM_WRITERS (NW),
    .MAX_STARVE  (MS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  // Tasks start and end 1 ns after a rising edge; outputs sampled at negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_writer(input int w, input logic [9:0] a, input logic [7:0] d);
    bus.wr_addr[w*10 +: 10] = a;
    bus.wr_data[w*8 +: 8]   = d;
  endtask

  task automatic write_mem(input int w, input logic [9:0] a, input logic [7:0] d);
    bit got = 1'b0;
    set_writer(w, a, d);
    bus.wr_req[w] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.wr_grant[w]) got = 1'b1;
      cyc();
    end
    bus.wr_req[w] = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL write_mem: writer %0d grant got none, want grant", w);
    end
  endtask

  task automatic read_check(input logic [9:0] a, input logic [7:0] exp, input string nm);
    bit ok = 1'b0;
    bus.pixel_address = a;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clk);
      if (bus.pixel_valid) ok = 1'b1;
      else cyc();
    end
    n_total++;
    if (!ok || bus.pixel_data !== exp)
      $display("FAIL %s: got valid=%0b data=%02h, want valid=1 data=%02h",
               nm, ok, bus.pixel_data, exp);
    else n_pass++;
    cyc();
  endtask

  task automatic test_reset();
    rst_n             = 1'b0;
    bus.pixel_address = '0;
    bus.wr_req        = '0;
    bus.wr_addr       = '0;
    bus.wr_data       = '0;
    repeat (3) cyc();
    bus.wr_req = 2'b11;
    @(negedge clk);
    n_total++;
    if (bus.pixel_valid !== 1'b0) $display("FAIL reset_valid: got %b, want 0", bus.pixel_valid);
    else n_pass++;
    n_total++;
    if (bus.pixel_data !== 8'h00) $display("FAIL reset_data: got %02h, want 00", bus.pixel_data);
    else n_pass++;
    n_total++;
    if (bus.wr_grant !== 2'b00) $display("FAIL reset_grant: got %b, want 00", bus.wr_grant);
    else n_pass++;
    cyc();
    bus.wr_req = '0;
    rst_n      = 1'b1;
    write_mem(0, 10'd5, 8'hA5);
  endtask

  task automatic test_read_after_reset();
    bus.pixel_address = 10'd5;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.pixel_valid !== 1'b0) $display("FAIL rd_c0_valid: got %b, want 0", bus.pixel_valid);
    else n_pass++;
    n_total++;
    if (bus.pixel_data !== 8'h00) $display("FAIL rd_c0_data: got %02h, want 00", bus.pixel_data);
    else n_pass++;
    cyc();
    cyc();
    @(negedge clk);
    n_total++;
    if (bus.pixel_valid !== 1'b1) $display("FAIL rd_c2_valid: got %b, want 1", bus.pixel_valid);
    else n_pass++;
    n_total++;
    if (bus.pixel_data !== 8'hA5) $display("FAIL rd_c2_data: got %02h, want a5", bus.pixel_data);
    else n_pass++;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    set_writer(0, 10'd100, 8'h11);
    set_writer(1, 10'd101, 8'h22);
    bus.wr_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_total++;
      if (bus.wr_grant !== exp_g[k])
        $display("FAIL rr_grant%0d: got %b, want %b", k, bus.wr_grant, exp_g[k]);
      else n_pass++;
      cyc();
    end
    bus.wr_req = '0;
    read_check(10'd100, 8'h11, "rr_data_w0");
    read_check(10'd101, 8'h22, "rr_data_w1");
  endtask

  task automatic test_starvation();
    int         first = -1;
    logic [1:0] g     = '0;
    set_writer(1, 10'd7, 8'h3C);
    for (int k = 0; k < 24 && first < 0; k++) begin
      bus.pixel_address = 10'(200 + k);
      if (k == 0) bus.wr_req[1] = 1'b1;
      @(negedge clk);
      if (bus.wr_grant !== 2'b00) begin
        first = k;
        g     = bus.wr_grant;
      end
      cyc();
    end
    bus.wr_req = '0;
    // 16 denied cycles (offsets 0..15) saturate the counter; offset 16 is forced.
    n_total++;
    if (first != 16) $display("FAIL starve_cycle: got %0d, want 16", first);
    else n_pass++;
    n_total++;
    if (g !== 2'b10) $display("FAIL starve_grant: got %b, want 10", g);
    else n_pass++;
    read_check(10'd7, 8'h3C, "starve_data");
  endtask

  task automatic test_coherence();
    write_mem(1, 10'd12, 8'h5A);
    read_check(10'd12, 8'h5A, "coh_pre");
    set_writer(0, 10'd12, 8'hFF);
    bus.wr_req[0] = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.wr_grant !== 2'b01 || bus.pixel_valid !== 1'b1)
      $display("FAIL coh_commit: got grant=%b valid=%b, want grant=01 valid=1",
               bus.wr_grant, bus.pixel_valid);
    else n_pass++;
    cyc();
    bus.wr_req = '0;
    @(negedge clk);
    n_total++;
    if (bus.pixel_valid !== 1'b0) $display("FAIL coh_drop: got %b, want 0", bus.pixel_valid);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_total++;
    if (bus.pixel_valid !== 1'b1 || bus.pixel_data !== 8'hFF)
      $display("FAIL coh_reread: got valid=%b data=%02h, want valid=1 data=ff",
               bus.pixel_valid, bus.pixel_data);
    else n_pass++;
    cyc();
  endtask

  task automatic test_reset_midwrite();
    set_writer(0, 10'd12, 8'h11);
    bus.wr_req[0] = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.wr_grant !== 2'b01) $display("FAIL mid_pre_grant: got %b, want 01", bus.wr_grant);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.wr_grant !== 2'b00 || bus.pixel_valid !== 1'b0 || bus.pixel_data !== 8'h00)
      $display("FAIL mid_reset_out: got grant=%b valid=%b data=%02h, want 00/0/00",
               bus.wr_grant, bus.pixel_valid, bus.pixel_data);
    else n_pass++;
    cyc();
    bus.wr_req = '0;
    cyc();
    rst_n = 1'b1;
    read_check(10'd12, 8'hFF, "mid_mem_kept");
    set_writer(0, 10'd300, 8'h01);
    set_writer(1, 10'd301, 8'h02);
    bus.wr_req = 2'b11;
    @(negedge clk);
    n_total++;
    if (bus.wr_grant !== 2'b01) $display("FAIL mid_rr_ptr: got %b, want 01", bus.wr_grant);
    else n_pass++;
    cyc();
    bus.wr_req = '0;
  endtask

`ifdef OLED_ARB_CLEAR_EN
  task automatic test_clear();
    int  busy_n = 0;
    int  bad_g  = 0;
    bit  seen   = 1'b0;
    bit  done   = 1'b0;
    bit  got    = 1'b0;
    set_writer(0, 10'd50, 8'h77);
    bus.wr_req[0]     = 1'b1;
    bus.clear_req     = 1'b1;
    bus.pixel_address = 10'd900;
    cyc();
    bus.clear_req = 1'b0;
    for (int i = 0; i < 1100 && !done; i++) begin
      @(negedge clk);
      if (bus.clear_busy) begin
        seen = 1'b1;
        busy_n++;
        if (bus.wr_grant !== 2'b00) bad_g++;
        cyc();
      end else if (seen) begin
        done = 1'b1;
      end else begin
        cyc();
      end
    end
    n_total++;
    if (busy_n != 1024) $display("FAIL clr_busy_len: got %0d, want 1024", busy_n);
    else n_pass++;
    n_total++;
    if (bad_g != 0) $display("FAIL clr_grants: got %0d, want 0", bad_g);
    else n_pass++;
    for (int i = 0; i < 8 && !got; i++) begin
      if (bus.wr_grant[0]) got = 1'b1;
      cyc();
      if (!got) @(negedge clk);
    end
    bus.wr_req = '0;
    n_total++;
    if (!got) $display("FAIL clr_pending: got no grant, want grant");
    else n_pass++;
    for (int a = 0; a < 1024; a++)
      read_check(10'(a), (a == 50) ? 8'h77 : 8'h00, "clr_zero");
  endtask
`endif

  initial begin
`ifdef OLED_ARB_CLEAR_EN
    bus.clear_req = 1'b0;
`endif
    test_reset();
    test_read_after_reset();
    test_round_robin();
    test_starvation();
    test_coherence();
    test_reset_midwrite();
`ifdef OLED_ARB_CLEAR_EN
    test_clear();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
